decade_count_sequencer: RTL and testbench
=========================================

// Module: decade_count_sequencer
// PURPOSE
//  Sequences one 4-bit BCD up/down decade counter from two raw, active-low board buttons and an auto-run tick.
//  Debounces the buttons and arbitrates up/down/auto requests.
//  Emits clean, spaced, active-low count strobes (cnt_up_n/cnt_dn_n) and the active-low counter clear.
//  Flags 9->0 and 0->9 wraps from the counter's carry/borrow outputs.
//  Sits between the board inputs and the decade counter that drives the 7-segment pins.
// PARAMETERS
//  DEBOUNCE    50000     cycles a synced button must hold a new level before the stable level changes (>=1)
//  PULSE_LEN   4         cycles a strobe is held low (>=1)
//  GAP_LEN     4         cycles both strobes stay high after a strobe before the next one (>=1)
//  CLR_CYCLES  2         cycles cnt_clr_n stays low after rst deasserts (>=1)
//  AUTO_DIV    25000000  cycles between auto-run up requests (>=2)
// PORTS
//  clk         in   1  system clock; all state updates on posedge
//  rst         in   1  synchronous, active-high reset
//  up_btn_n    in   1  raw up button, 0 = pressed, asynchronous
//  dn_btn_n    in   1  raw down button, 0 = pressed, asynchronous
//  auto_en     in   1  1 = issue an up request every AUTO_DIV cycles
//  cu_n        in   1  counter carry-out, low when digit=9 and up strobe low
//  cd_n        in   1  counter borrow-out, low when digit=0 and down strobe low
//  cnt_up_n    out  1  up count strobe to counter, idle 1
//  cnt_dn_n    out  1  down count strobe to counter, idle 1
//  cnt_clr_n   out  1  counter clear, active low
//  busy        out  1  1 whenever state != IDLE or a request is pending
//  wrap_up     out  1  one-cycle pulse: a completed up strobe wrapped 9->0
//  wrap_dn     out  1  one-cycle pulse: a completed down strobe wrapped 0->9
// BEHAVIOUR
//  Reset (rst=1, sampled on posedge)
//   - All registers cleared; synchronisers and stable levels set to 1 (released).
//   - Outputs: cnt_up_n=1, cnt_dn_n=1, cnt_clr_n=0, busy=1, wrap_up=0, wrap_dn=0.
//   - Pending flags and the auto counter clear.
//   - rst asserted mid-strobe returns the strobe high on the next edge; the request is lost.
//  Button path, each button
//   - 2-FF synchroniser, then debounce counter.
//   - Counter resets whenever synced level == stable level, otherwise increments.
//   - On reaching DEBOUNCE, stable takes the synced level and the counter clears.
//   - Press event is a registered 1-cycle pulse on the stable 1->0 edge only; releases generate nothing.
//  Auto tick
//   - Counter runs only while auto_en=1 and state != CLEAR; at AUTO_DIV-1 it wraps to 0 and raises a 1-cycle up request.
//   - auto_en=0 clears the counter.
//  Request arbitration (one-deep pending flag per direction: pend_up, pend_dn)
//   - up request = up press OR auto tick; a second up request while pend_up=1 is merged (dropped).
//   - Up and down requests in the same cycle cancel; flags unchanged.
//   - A request opposite to an already-set flag clears that flag instead of setting its own (net zero).
//   - So pend_up and pend_dn are never both 1.
//   - A flag clears on the cycle the FSM enters LOW for it.
//  FSM: CLEAR, IDLE, LOW, GAP
//   - CLEAR: cnt_clr_n=0 for CLR_CYCLES cycles after rst falls, then IDLE; requests arriving in CLEAR are ignored.
//   - IDLE: if pend_up, go LOW dir=up; else if pend_dn, go LOW dir=dn; else stay.
//   - LOW: selected strobe = 0 for exactly PULSE_LEN cycles; the other strobe stays 1.
//     cu_n (up) / cd_n (dn) is sampled on the last LOW cycle into wrap_flag.
//   - GAP: both strobes 1 for GAP_LEN cycles, then IDLE. On the first GAP cycle wrap_up/wrap_dn = wrap_flag for dir.
//   - Requests arriving in LOW/GAP only set pending flags; they are serviced from IDLE.
//   - Minimum strobe period is PULSE_LEN+GAP_LEN+1.
//  Latency
//   - Stable press edge to press pulse: 1 cycle. Press pulse to pending: 1 cycle. Pending to LOW from IDLE: 1 cycle.
//   - So cnt_*_n falls 3 cycles after the stable level changes.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING (bench uses DEBOUNCE=4, PULSE_LEN=2, GAP_LEN=2, CLR_CYCLES=2, AUTO_DIV=20)
//  1 Reset: rst=1 for 3 cycles then 0 -> cnt_clr_n=0 through 2 cycles after rst falls, then 1; strobes stay 1.
//  2 Bounce: up_btn_n toggles every 2 cycles for 20 cycles, then holds 0 -> exactly one cnt_up_n low pulse,
//    2 cycles wide, no cnt_dn_n activity.
//  3 Wrap: model the counter at digit 9 with cu_n low during the up strobe -> wrap_up=1 for exactly 1 cycle
//    on the first GAP cycle; same with cd_n at 0 -> wrap_dn.
//  4 Simultaneous press: both buttons held 0 from the same cycle -> no strobe, busy returns 0;
//    up pressed during a down strobe with pend_dn=1 -> pend_dn cleared, nothing further issued.
//  5 Auto: auto_en=1 for 100 cycles -> exactly 5 cnt_up_n pulses, 20 cycles apart; deassert -> no further pulses.
//  6 Reset mid-LOW: rst=1 in the first LOW cycle -> cnt_up_n=1 next edge, pending clear, CLEAR sequence repeats.

Source files
------------

// File: rtl/decade_count_sequencer.sv
// Turns two raw active-low buttons and an auto-run tick into spaced, registered
// count strobes for one BCD decade counter, plus clear and 9->0 / 0->9 wrap flags.
module decade_count_sequencer #(
    parameter int DEBOUNCE   = 50000,
    parameter int PULSE_LEN  = 4,
    parameter int GAP_LEN    = 4,
    parameter int CLR_CYCLES = 2,
    parameter int AUTO_DIV   = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic up_btn_n,
    input  logic dn_btn_n,
    input  logic auto_en,
    input  logic cu_n,
    input  logic cd_n,
    output logic cnt_up_n,
    output logic cnt_dn_n,
    output logic cnt_clr_n,
    output logic busy,
    output logic wrap_up,
    output logic wrap_dn
);

    localparam int DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int AD_W    = $clog2(AUTO_DIV);
    localparam int TMR_MAX = (PULSE_LEN > GAP_LEN)
                           ? ((PULSE_LEN > CLR_CYCLES) ? PULSE_LEN : CLR_CYCLES)
                           : ((GAP_LEN > CLR_CYCLES) ? GAP_LEN : CLR_CYCLES);
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOW,
        ST_GAP
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DN
    } dir_t;

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = up, index 1 = down
    // ------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] press;

    assign btn_raw = {dn_btn_n, up_btn_n};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            stable_reg;
            logic            stable_prev_reg;
            logic            press_reg;
            logic [DB_W-1:0] db_cnt_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg       <= 1'b1;
                    sync2_reg       <= 1'b1;
                    stable_reg      <= 1'b1;
                    stable_prev_reg <= 1'b1;
                    press_reg       <= 1'b0;
                    db_cnt_reg      <= '0;
                end else begin
                    sync1_reg       <= btn_raw[gi];
                    sync2_reg       <= sync1_reg;
                    stable_prev_reg <= stable_reg;
                    // Only the released->pressed transition of the clean level counts
                    press_reg       <= stable_prev_reg & ~stable_reg;
                    if (sync2_reg == stable_reg) begin
                        db_cnt_reg <= '0;
                    end else if (db_cnt_reg == DB_W'(DEBOUNCE - 1)) begin
                        stable_reg <= sync2_reg;
                        db_cnt_reg <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + DB_W'(1);
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    dir_t             dir_reg, dir_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic             pend_up_reg, pend_up_next;
    logic             pend_dn_reg, pend_dn_next;
    logic [AD_W-1:0]  auto_cnt_reg;
    logic             auto_tick_reg;
    logic             cnt_up_n_reg, cnt_dn_n_reg, cnt_clr_n_reg;
    logic             busy_reg, wrap_up_reg, wrap_dn_reg;
    logic             wrap_up_next, wrap_dn_next;
    logic             up_req, dn_req;

    // ------------------------------------------------------------------
    // Auto-run tick generator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt_reg  <= '0;
            auto_tick_reg <= 1'b0;
        end else if (!auto_en || state_reg == ST_CLEAR) begin
            auto_cnt_reg  <= '0;
            auto_tick_reg <= 1'b0;
        end else if (auto_cnt_reg == AD_W'(AUTO_DIV - 1)) begin
            auto_cnt_reg  <= '0;
            auto_tick_reg <= 1'b1;
        end else begin
            auto_cnt_reg  <= auto_cnt_reg + AD_W'(1);
            auto_tick_reg <= 1'b0;
        end
    end

    assign up_req = press[0] | auto_tick_reg;
    assign dn_req = press[1];

    // ------------------------------------------------------------------
    // Request arbitration into the one-deep pending flags
    // ------------------------------------------------------------------
    always_comb begin
        pend_up_next = pend_up_reg;
        pend_dn_next = pend_dn_reg;
        if (state_reg == ST_CLEAR) begin
            pend_up_next = 1'b0;
            pend_dn_next = 1'b0;
        end else begin
            // An opposite request annihilates a pending one rather than queueing
            if (up_req && !dn_req) begin
                if (pend_dn_reg) pend_dn_next = 1'b0;
                else             pend_up_next = 1'b1;
            end else if (dn_req && !up_req) begin
                if (pend_up_reg) pend_up_next = 1'b0;
                else             pend_dn_next = 1'b1;
            end
            if (state_reg == ST_IDLE && pend_up_reg) begin
                pend_up_next = 1'b0;
            end else if (state_reg == ST_IDLE && pend_dn_reg) begin
                pend_dn_next = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobe sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        tmr_next     = tmr_reg;
        wrap_up_next = 1'b0;
        wrap_dn_next = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                if (tmr_reg == TMR_W'(CLR_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            ST_IDLE: begin
                if (pend_up_reg) begin
                    state_next = ST_LOW;
                    dir_next   = DIR_UP;
                    tmr_next   = '0;
                end else if (pend_dn_reg) begin
                    state_next = ST_LOW;
                    dir_next   = DIR_DN;
                    tmr_next   = '0;
                end
            end
            ST_LOW: begin
                if (tmr_reg == TMR_W'(PULSE_LEN - 1)) begin
                    state_next = ST_GAP;
                    tmr_next   = '0;
                    // Carry/borrow is valid while our strobe is still low
                    wrap_up_next = (dir_reg == DIR_UP) & ~cu_n;
                    wrap_dn_next = (dir_reg == DIR_DN) & ~cd_n;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (tmr_reg == TMR_W'(GAP_LEN - 1)) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = ST_CLEAR;
                tmr_next   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_CLEAR;
            dir_reg       <= DIR_UP;
            tmr_reg       <= '0;
            pend_up_reg   <= 1'b0;
            pend_dn_reg   <= 1'b0;
            cnt_up_n_reg  <= 1'b1;
            cnt_dn_n_reg  <= 1'b1;
            cnt_clr_n_reg <= 1'b0;
            busy_reg      <= 1'b1;
            wrap_up_reg   <= 1'b0;
            wrap_dn_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dir_reg       <= dir_next;
            tmr_reg       <= tmr_next;
            pend_up_reg   <= pend_up_next;
            pend_dn_reg   <= pend_dn_next;
            cnt_up_n_reg  <= ~(state_next == ST_LOW && dir_next == DIR_UP);
            cnt_dn_n_reg  <= ~(state_next == ST_LOW && dir_next == DIR_DN);
            cnt_clr_n_reg <= (state_next != ST_CLEAR);
            busy_reg      <= (state_next != ST_IDLE) | pend_up_next | pend_dn_next;
            wrap_up_reg   <= wrap_up_next;
            wrap_dn_reg   <= wrap_dn_next;
        end
    end

    assign cnt_up_n  = cnt_up_n_reg;
    assign cnt_dn_n  = cnt_dn_n_reg;
    assign cnt_clr_n = cnt_clr_n_reg;
    assign busy      = busy_reg;
    assign wrap_up   = wrap_up_reg;
    assign wrap_dn   = wrap_dn_reg;

endmodule

// File: tb/tb_decade_count_sequencer.sv
// Directed bench for decade_count_sequencer: reset/clear, debounce, wrap flags,
// request arbitration, auto-run and reset in the middle of a strobe.
module tb_decade_count_sequencer;

    logic clk = 1'b0;
    logic rst, up_btn_n, dn_btn_n, auto_en, cu_n, cd_n;
    logic cnt_up_n, cnt_dn_n, cnt_clr_n, busy, wrap_up, wrap_dn;
    logic [3:0] digit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decade_count_sequencer #(
        .DEBOUNCE  (4),
        .PULSE_LEN (2),
        .GAP_LEN   (2),
        .CLR_CYCLES(2),
        .AUTO_DIV  (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .up_btn_n (up_btn_n),
        .dn_btn_n (dn_btn_n),
        .auto_en  (auto_en),
        .cu_n     (cu_n),
        .cd_n     (cd_n),
        .cnt_up_n (cnt_up_n),
        .cnt_dn_n (cnt_dn_n),
        .cnt_clr_n(cnt_clr_n),
        .busy     (busy),
        .wrap_up  (wrap_up),
        .wrap_dn  (wrap_dn)
    );

    // Decade counter stand-in: carry/borrow only depend on a fixed digit and the strobe
    assign cu_n = ~((digit == 4'd9) & ~cnt_up_n);
    assign cd_n = ~((digit == 4'd0) & ~cnt_dn_n);

    // Strobe monitor, sampled on the falling edge
    int   cyc_no = 0;
    int   up_falls, dn_falls, up_width, dn_width, up_run, dn_run;
    int   wrap_up_cnt, wrap_dn_cnt, wrap_up_on_rise, wrap_dn_on_rise, both_low;
    int   up_fall_at[$];
    int   dn_fall_at[$];
    logic prev_up = 1'b1;
    logic prev_dn = 1'b1;

    always @(negedge clk) begin
        cyc_no++;
        if (cnt_up_n === 1'b0) begin
            if (prev_up === 1'b1) begin
                up_falls++;
                up_fall_at.push_back(cyc_no);
                up_run = 0;
            end
            up_run++;
        end else if (prev_up === 1'b0) begin
            up_width = up_run;
            if (wrap_up === 1'b1) wrap_up_on_rise++;
        end
        if (cnt_dn_n === 1'b0) begin
            if (prev_dn === 1'b1) begin
                dn_falls++;
                dn_fall_at.push_back(cyc_no);
                dn_run = 0;
            end
            dn_run++;
        end else if (prev_dn === 1'b0) begin
            dn_width = dn_run;
            if (wrap_dn === 1'b1) wrap_dn_on_rise++;
        end
        if (wrap_up === 1'b1) wrap_up_cnt++;
        if (wrap_dn === 1'b1) wrap_dn_cnt++;
        if (cnt_up_n === 1'b0 && cnt_dn_n === 1'b0) both_low++;
        prev_up = cnt_up_n;
        prev_dn = cnt_dn_n;
    end

    task automatic clear_mon();
        up_falls = 0; dn_falls = 0; up_width = 0; dn_width = 0;
        wrap_up_cnt = 0; wrap_dn_cnt = 0; wrap_up_on_rise = 0; wrap_dn_on_rise = 0;
        both_low = 0;
        up_fall_at.delete();
        dn_fall_at.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; up_btn_n = 1'b1; dn_btn_n = 1'b1; auto_en = 1'b0; digit = 4'd5;
        clear_mon();

        // Reset and clear sequence
        cyc(3);
        check("rst_clr_n",   cnt_clr_n, 0);
        check("rst_busy",    busy, 1);
        check("rst_up_n",    cnt_up_n, 1);
        check("rst_dn_n",    cnt_dn_n, 1);
        check("rst_wrap_up", wrap_up, 0);
        check("rst_wrap_dn", wrap_dn, 0);
        rst = 1'b0;
        cyc(1);
        check("clear_c1_clr_n", cnt_clr_n, 0);
        cyc(1);
        check("clear_c2_clr_n", cnt_clr_n, 1);
        check("clear_c2_busy",  busy, 0);
        check("clear_c2_up_n",  cnt_up_n, 1);
        cyc(5);

        // Bouncing up button, then a solid press
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            up_btn_n = (i % 2 == 1);
            cyc(2);
        end
        up_btn_n = 1'b0;
        cyc(30);
        check("bounce_up_pulses", up_falls, 1);
        check("bounce_up_width",  up_width, 2);
        check("bounce_dn_pulses", dn_falls, 0);
        up_btn_n = 1'b1;
        cyc(15);
        check("release_no_pulse", up_falls, 1);
        check("release_busy",     busy, 0);

        // Up wrap 9->0 with exact latency from the raw press
        digit = 4'd9;
        clear_mon();
        up_btn_n = 1'b0;
        cyc(8);
        check("lat_up_n_high", cnt_up_n, 1);
        check("lat_busy_pend", busy, 1);
        cyc(1);
        check("lat_up_n_low1", cnt_up_n, 0);
        cyc(1);
        check("lat_up_n_low2", cnt_up_n, 0);
        check("wrap_up_early", wrap_up, 0);
        cyc(1);
        check("gap1_up_n",     cnt_up_n, 1);
        check("gap1_wrap_up",  wrap_up, 1);
        cyc(1);
        check("gap2_wrap_up",  wrap_up, 0);
        cyc(1);
        check("idle_busy",     busy, 0);
        up_btn_n = 1'b1;
        cyc(15);
        check("wrap_up_count",   wrap_up_cnt, 1);
        check("wrap_up_on_rise", wrap_up_on_rise, 1);
        check("wrap_up_no_dn",   wrap_dn_cnt, 0);

        // Down wrap 0->9
        digit = 4'd0;
        clear_mon();
        dn_btn_n = 1'b0;
        cyc(20);
        dn_btn_n = 1'b1;
        cyc(15);
        check("wrap_dn_pulses",  dn_falls, 1);
        check("wrap_dn_width",   dn_width, 2);
        check("wrap_dn_count",   wrap_dn_cnt, 1);
        check("wrap_dn_on_rise", wrap_dn_on_rise, 1);
        check("wrap_dn_no_up",   up_falls + wrap_up_cnt, 0);

        // Mid-range digit: strobe but no wrap
        digit = 4'd5;
        clear_mon();
        up_btn_n = 1'b0;
        cyc(20);
        up_btn_n = 1'b1;
        cyc(15);
        check("nowrap_up_pulses", up_falls, 1);
        check("nowrap_up_flag",   wrap_up_cnt, 0);

        // Both buttons pressed in the same cycle cancel
        clear_mon();
        up_btn_n = 1'b0; dn_btn_n = 1'b0;
        cyc(20);
        check("simul_up_pulses", up_falls, 0);
        check("simul_dn_pulses", dn_falls, 0);
        check("simul_busy",      busy, 0);
        up_btn_n = 1'b1; dn_btn_n = 1'b1;
        cyc(15);

        // Down press one cycle behind up: annihilates the pending up, only one up strobe
        clear_mon();
        up_btn_n = 1'b0;
        cyc(1);
        dn_btn_n = 1'b0;
        cyc(25);
        check("cancel_up_pulses", up_falls, 1);
        check("cancel_dn_pulses", dn_falls, 0);
        check("cancel_busy",      busy, 0);
        up_btn_n = 1'b1; dn_btn_n = 1'b1;
        cyc(15);

        // Down press landing during the up strobe is queued and serviced after the gap
        clear_mon();
        up_btn_n = 1'b0;
        cyc(2);
        dn_btn_n = 1'b0;
        cyc(30);
        check("queue_up_pulses", up_falls, 1);
        check("queue_dn_pulses", dn_falls, 1);
        if (up_falls == 1 && dn_falls == 1)
            check("queue_spacing", dn_fall_at[0] - up_fall_at[0], 5);
        check("queue_never_both", both_low, 0);
        up_btn_n = 1'b1; dn_btn_n = 1'b1;
        cyc(15);

        // Auto-run for 100 cycles
        clear_mon();
        auto_en = 1'b1;
        cyc(100);
        auto_en = 1'b0;
        cyc(40);
        check("auto_pulses",    up_falls, 5);
        check("auto_dn_pulses", dn_falls, 0);
        for (int k = 1; k < up_fall_at.size(); k++)
            check("auto_spacing", up_fall_at[k] - up_fall_at[k-1], 20);
        clear_mon();
        cyc(60);
        check("auto_off_pulses", up_falls, 0);

        // Reset asserted in the first LOW cycle
        clear_mon();
        up_btn_n = 1'b0;
        for (int n = 0; n < 20 && cnt_up_n !== 1'b0; n++) cyc(1);
        check("midlow_seen_low", cnt_up_n, 0);
        rst = 1'b1; up_btn_n = 1'b1;
        cyc(1);
        check("midlow_up_n",  cnt_up_n, 1);
        check("midlow_clr_n", cnt_clr_n, 0);
        check("midlow_busy",  busy, 1);
        rst = 1'b0;
        cyc(1);
        check("midlow_c1_clr_n", cnt_clr_n, 0);
        cyc(1);
        check("midlow_c2_clr_n", cnt_clr_n, 1);
        check("midlow_c2_busy",  busy, 0);
        cyc(20);
        check("midlow_no_retry", up_falls, 1);
        check("midlow_no_wrap",  wrap_up_cnt + wrap_dn_cnt, 0);
        check("midlow_no_dn",    dn_falls, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
